// File: rtl/spdot_bsr_engine.sv
// spdot_bsr_engine: walks a BSR index and streams LANES-wide Q.K scores.
// Build option SPDOT_SATURATE_EN: saturating accumulator instead of wrap.
module spdot_bsr_engine #(
  parameter int DATA_W = 16,
  parameter int LANES  = 4,
  parameter int ACC_W  = 48,
  parameter int ADDR_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [15:0]             m_rows,
  input  logic [15:0]             head_dim_d,
  input  logic [15:0]             block_size,
  output logic [ADDR_W-1:0]       rp_raddr,
  input  logic [ADDR_W-1:0]       rp_rdata,
  output logic [ADDR_W-1:0]       ci_raddr,
  input  logic [ADDR_W-1:0]       ci_rdata,
  output logic [ADDR_W-1:0]       q_raddr,
  input  logic [LANES*DATA_W-1:0] q_rdata,
  output logic [ADDR_W-1:0]       k_raddr,
  input  logic [LANES*DATA_W-1:0] k_rdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             out_row,
  output logic [15:0]             out_tok,
  output logic [ACC_W-1:0]        out_score,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [63:0]             checksum_out
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = PROD_W + $clog2(LANES) + 1;
  localparam int EXT_W  =
    ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 2;

  typedef enum logic [3:0] {
    S_IDLE, S_RP0, S_RP1, S_RP2, S_CI,
    S_CIW, S_MAC, S_EMIT, S_NEXTROW, S_DONE
  } state_t;

  state_t              state;
  logic [15:0]         rows_q;
  logic [15:0]         bsz_q;
  logic [15:0]         w_q;
  logic [15:0]         row;
  logic [15:0]         t;
  logic [15:0]         tok;
  logic [15:0]         mcnt;
  logic [ADDR_W-1:0]   blk;
  logic [ADDR_W-1:0]   blk_end;
  logic [ACC_W-1:0]    acc;
  logic [63:0]         checksum;

  function automatic logic [31:0] mul_lo(
    input logic [31:0] a,
    input logic [31:0] b
  );
    return a * b;
  endfunction

  function automatic logic signed [PROD_W-1:0] lane_mul(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [PROD_W-1:0] ea;
    logic signed [PROD_W-1:0] eb;
    ea = PROD_W'(a);
    eb = PROD_W'(b);
    return ea * eb;
  endfunction

  logic [15:0]       w_cfg;
  logic              cfg_bad;
  logic              cfg_empty;
  logic [15:0]       row_inc;
  logic              row_more;
  logic [15:0]       t_inc;
  logic [15:0]       tok_inc;
  logic [15:0]       tok_ci;
  logic [ADDR_W-1:0] blk_inc;
  logic [ADDR_W-1:0] q_base;
  logic [ADDR_W-1:0] k_base_ci;
  logic [ADDR_W-1:0] k_base_nx;

  assign w_cfg   = head_dim_d / 16'(LANES);
  assign cfg_bad = (head_dim_d == 16'd0)
                || ((head_dim_d % 16'(LANES)) != 16'd0)
                || (block_size == 16'd0);
  assign cfg_empty = !cfg_bad && (m_rows == 16'd0);

  assign row_inc  = row + 16'd1;
  assign row_more = ({1'b0, row} + 17'd1) < {1'b0, rows_q};
  assign t_inc    = t + 16'd1;
  assign tok_inc  = tok + 16'd1;
  assign blk_inc  = blk + ADDR_W'(1);

  // Absolute token and word bases, all truncated to their field widths.
  assign tok_ci    = 16'(mul_lo(32'(ci_rdata), 32'(bsz_q)));
  assign q_base    = ADDR_W'(mul_lo(32'(row), 32'(w_q)));
  assign k_base_ci = ADDR_W'(mul_lo(32'(tok_ci), 32'(w_q)));
  assign k_base_nx = ADDR_W'(mul_lo(32'(tok_inc), 32'(w_q)));

  logic signed [SUM_W-1:0] dot_sum;
  always_comb begin
    dot_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      dot_sum = dot_sum + SUM_W'(lane_mul(
        q_rdata[i*DATA_W +: DATA_W],
        k_rdata[i*DATA_W +: DATA_W]));
    end
  end

  logic [ACC_W-1:0] acc_nx;
`ifdef SPDOT_SATURATE_EN
  localparam logic signed [EXT_W-1:0] ACC_MAX =
    EXT_W'({1'b0, {(ACC_W-1){1'b1}}});
  localparam logic signed [EXT_W-1:0] ACC_MIN = ~ACC_MAX;
  logic signed [EXT_W-1:0] acc_ext;
  always_comb begin
    acc_ext = EXT_W'($signed(acc)) + EXT_W'(dot_sum);
    acc_nx  = ACC_W'(acc_ext);
    if (acc_ext > ACC_MAX) acc_nx = ACC_W'(ACC_MAX);
    if (acc_ext < ACC_MIN) acc_nx = ACC_W'(ACC_MIN);
  end
`else
  always_comb begin
    acc_nx = acc + ACC_W'(dot_sum);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      rows_q       <= '0;
      bsz_q        <= '0;
      w_q          <= '0;
      row          <= '0;
      t            <= '0;
      tok          <= '0;
      mcnt         <= '0;
      blk          <= '0;
      blk_end      <= '0;
      acc          <= '0;
      checksum     <= '0;
      rp_raddr     <= '0;
      ci_raddr     <= '0;
      q_raddr      <= '0;
      k_raddr      <= '0;
      out_valid    <= 1'b0;
      out_row      <= '0;
      out_tok      <= '0;
      out_score    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      checksum_out <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            busy   <= 1'b1;
            err    <= 1'b0;
            rows_q <= m_rows;
            bsz_q  <= block_size;
            w_q    <= w_cfg;
            unique case (1'b1)
              cfg_bad: begin
                err          <= 1'b1;
                done         <= 1'b1;
                checksum_out <= checksum;
                state        <= S_DONE;
              end
              cfg_empty: begin
                done         <= 1'b1;
                checksum_out <= checksum;
                state        <= S_DONE;
              end
              default: begin
                checksum <= '0;
                row      <= '0;
                rp_raddr <= '0;
                state    <= S_RP0;
              end
            endcase
          end
        end
        S_RP0: begin
          rp_raddr <= ADDR_W'(row_inc);
          state    <= S_RP1;
        end
        S_RP1: begin
          blk   <= rp_rdata;
          state <= S_RP2;
        end
        S_RP2: begin
          blk_end <= rp_rdata;
          if (blk == rp_rdata) begin
            state <= S_NEXTROW;
          end else begin
            ci_raddr <= blk;
            state    <= S_CI;
          end
        end
        S_CI: state <= S_CIW;
        S_CIW: begin
          t       <= '0;
          tok     <= tok_ci;
          q_raddr <= q_base;
          k_raddr <= k_base_ci;
          acc     <= '0;
          mcnt    <= '0;
          state   <= S_MAC;
        end
        // mcnt 0..W-1 issue words; data lags one cycle, mcnt==W drains.
        S_MAC: begin
          mcnt <= mcnt + 16'd1;
          if (mcnt != 16'd0) acc <= acc_nx;
          if ((mcnt + 16'd1) < w_q) begin
            q_raddr <= q_raddr + ADDR_W'(1);
            k_raddr <= k_raddr + ADDR_W'(1);
          end
          if (mcnt == w_q) begin
            out_score <= acc_nx;
            out_row   <= row;
            out_tok   <= tok;
            out_valid <= 1'b1;
            state     <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            checksum  <= checksum + 64'($signed(out_score));
            if (t_inc == bsz_q) begin
              t   <= '0;
              blk <= blk_inc;
              if (blk_inc == blk_end) begin
                state <= S_NEXTROW;
              end else begin
                ci_raddr <= blk_inc;
                state    <= S_CI;
              end
            end else begin
              t       <= t_inc;
              tok     <= tok_inc;
              q_raddr <= q_base;
              k_raddr <= k_base_nx;
              acc     <= '0;
              mcnt    <= '0;
              state   <= S_MAC;
            end
          end
        end
        S_NEXTROW: begin
          if (row_more) begin
            row      <= row_inc;
            rp_raddr <= ADDR_W'(row_inc);
            state    <= S_RP0;
          end else begin
            done         <= 1'b1;
            checksum_out <= checksum;
            state        <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spdot_bsr_engine.sv
// tb_spdot_bsr_engine: directed checks of spdot_bsr_engine with
// LANES=4, DATA_W=16, ACC_W=32 and 1-cycle synchronous RAM models.
module tb_spdot_bsr_engine;

  localparam int DW = 16;
  localparam int LN = 4;
  localparam int AW = 32;
  localparam int RW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [15:0]       m_rows;
  logic [15:0]       head_dim_d;
  logic [15:0]       block_size;
  logic [RW-1:0]     rp_raddr;
  logic [RW-1:0]     rp_rdata;
  logic [RW-1:0]     ci_raddr;
  logic [RW-1:0]     ci_rdata;
  logic [RW-1:0]     q_raddr;
  logic [LN*DW-1:0]  q_rdata;
  logic [RW-1:0]     k_raddr;
  logic [LN*DW-1:0]  k_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_row;
  logic [15:0]       out_tok;
  logic [AW-1:0]     out_score;
  logic              busy;
  logic              done;
  logic              err;
  logic [63:0]       checksum_out;

  spdot_bsr_engine #(
    .DATA_W(DW), .LANES(LN), .ACC_W(AW), .ADDR_W(RW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .m_rows(m_rows), .head_dim_d(head_dim_d),
    .block_size(block_size),
    .rp_raddr(rp_raddr), .rp_rdata(rp_rdata),
    .ci_raddr(ci_raddr), .ci_rdata(ci_rdata),
    .q_raddr(q_raddr), .q_rdata(q_rdata),
    .k_raddr(k_raddr), .k_rdata(k_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_tok(out_tok),
    .out_score(out_score),
    .busy(busy), .done(done), .err(err),
    .checksum_out(checksum_out)
  );

  always #5 clk = ~clk;

  logic [15:0] rp_mem [16];
  logic [15:0] ci_mem [16];
  logic [63:0] q_mem  [16];
  logic [63:0] k_mem  [16];

  always @(posedge clk) begin
    rp_rdata <= rp_mem[rp_raddr[3:0]];
    ci_rdata <= ci_mem[ci_raddr[3:0]];
    q_rdata  <= q_mem[q_raddr[3:0]];
    k_rdata  <= k_mem[k_raddr[3:0]];
  end

  int done_cnt = 0;
  int emit_cnt = 0;
  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (out_valid && out_ready) emit_cnt <= emit_cnt + 1;
  end

  int n_cmp = 0;
  int n_err = 0;
  int d0;
  int e0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int a0, input int a1,
                                     input int a2, input int a3);
    return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  task automatic cfg(input int r, input int h, input int b);
    m_rows     = 16'(r);
    head_dim_d = 16'(h);
    block_size = 16'(b);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
  endtask

  task automatic expect_emit(input string tag,
                             input logic [15:0] row,
                             input logic [15:0] tok,
                             input logic [31:0] score);
    wait_valid(tag);
    chk({tag, "_row"}, 64'(out_row), 64'(row));
    chk({tag, "_tok"}, 64'(out_tok), 64'(tok));
    chk({tag, "_score"}, 64'(out_score), 64'(score));
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic load_s1();
    rp_mem[0] = 16'd0;
    rp_mem[1] = 16'd1;
    ci_mem[0] = 16'd0;
    q_mem[0]  = pk(1, 2, 3, 4);
    k_mem[0]  = pk(1, 1, 1, 1);
    k_mem[1]  = pk(2, 0, 0, -1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    cfg(0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      rp_mem[i] = '0;
      ci_mem[i] = '0;
      q_mem[i]  = '0;
      k_mem[i]  = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_csum", checksum_out, 64'd0);
    chk("rst_score", 64'(out_score), 64'd0);
    chk("rst_qaddr", 64'(q_raddr), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // basic dot products
    load_s1();
    cfg(1, 4, 2);
    d0 = done_cnt;
    e0 = emit_cnt;
    pulse_start();
    chk("s1_busy", 64'(busy), 64'd1);
    expect_emit("s1_t0", 16'd0, 16'd0, 32'd10);
    expect_emit("s1_t1", 16'd0, 16'd1, 32'hFFFF_FFFE);
    wait_done("s1");
    chk("s1_csum", checksum_out, 64'd8);
    chk("s1_err", 64'(err), 64'd0);
    repeat (3) @(negedge clk);
    chk("s1_ndone", 64'(done_cnt - d0), 64'd1);
    chk("s1_nemit", 64'(emit_cnt - e0), 64'd2);
    chk("s1_idle", 64'(busy), 64'd0);

    // empty row 0, row 1 uses block column 3
    rp_mem[0] = 16'd0;
    rp_mem[1] = 16'd0;
    rp_mem[2] = 16'd1;
    ci_mem[0] = 16'd3;
    q_mem[1]  = pk(1, -1, 2, 3);
    k_mem[6]  = pk(3, 4, 5, 6);
    k_mem[7]  = pk(-1, -1, -1, -1);
    cfg(2, 4, 2);
    d0 = done_cnt;
    e0 = emit_cnt;
    pulse_start();
    expect_emit("s2_t6", 16'd1, 16'd6, 32'd27);
    expect_emit("s2_t7", 16'd1, 16'd7, 32'hFFFF_FFFB);
    wait_done("s2");
    chk("s2_csum", checksum_out, 64'd22);
    repeat (3) @(negedge clk);
    chk("s2_nemit", 64'(emit_cnt - e0), 64'd2);
    chk("s2_ndone", 64'(done_cnt - d0), 64'd1);

    // bad configs and zero rows
    cfg(1, 6, 2);
    d0 = done_cnt;
    e0 = emit_cnt;
    pulse_start();
    chk("bad_hd_done", 64'(done), 64'd1);
    chk("bad_hd_err", 64'(err), 64'd1);
    repeat (3) @(negedge clk);
    chk("bad_hd_hold", 64'(err), 64'd1);
    chk("bad_hd_nemit", 64'(emit_cnt - e0), 64'd0);
    chk("bad_hd_ndone", 64'(done_cnt - d0), 64'd1);
    cfg(1, 4, 0);
    pulse_start();
    chk("bad_bs_done", 64'(done), 64'd1);
    chk("bad_bs_err", 64'(err), 64'd1);
    repeat (3) @(negedge clk);
    cfg(0, 4, 2);
    e0 = emit_cnt;
    pulse_start();
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_err", 64'(err), 64'd0);
    repeat (3) @(negedge clk);
    chk("zero_nemit", 64'(emit_cnt - e0), 64'd0);

    // reset during MAC of row 0, then rerun
    load_s1();
    cfg(1, 4, 2);
    d0 = done_cnt;
    pulse_start();
    repeat (5) @(negedge clk);
    chk("s5_prebusy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("s5_busy", 64'(busy), 64'd0);
    chk("s5_rpaddr", 64'(rp_raddr), 64'd0);
    chk("s5_valid", 64'(out_valid), 64'd0);
    chk("s5_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("s5_nodone", 64'(done_cnt - d0), 64'd0);
    e0 = emit_cnt;
    pulse_start();
    expect_emit("s5_t0", 16'd0, 16'd0, 32'd10);
    expect_emit("s5_t1", 16'd0, 16'd1, 32'hFFFF_FFFE);
    wait_done("s5");
    chk("s5_csum", checksum_out, 64'd8);
    repeat (3) @(negedge clk);
    chk("s5_nemit", 64'(emit_cnt - e0), 64'd2);
    chk("s5_ndone", 64'(done_cnt - d0), 64'd1);

    // backpressure, two words per vector
    q_mem[0] = pk(1, 2, 3, 4);
    q_mem[1] = pk(5, 6, 7, 8);
    k_mem[0] = pk(1, 1, 1, 1);
    k_mem[1] = pk(1, 0, 0, 0);
    k_mem[2] = pk(2, 0, 0, -1);
    k_mem[3] = pk(0, 0, 0, 1);
    cfg(1, 8, 2);
    e0 = emit_cnt;
    out_ready = 1'b0;
    pulse_start();
    wait_valid("s3_stall");
    for (int i = 0; i < 5; i++) begin
      chk("s3_hold_valid", 64'(out_valid), 64'd1);
      chk("s3_hold_row", 64'(out_row), 64'd0);
      chk("s3_hold_tok", 64'(out_tok), 64'd0);
      chk("s3_hold_score", 64'(out_score), 64'd15);
      chk("s3_hold_q", 64'(q_raddr), 64'd1);
      chk("s3_hold_k", 64'(k_raddr), 64'd1);
      @(negedge clk);
    end
    chk("s3_stall_nemit", 64'(emit_cnt - e0), 64'd0);
    out_ready = 1'b1;
    expect_emit("s3_t0", 16'd0, 16'd0, 32'd15);
    expect_emit("s3_t1", 16'd0, 16'd1, 32'd6);
    wait_done("s3");
    chk("s3_csum", checksum_out, 64'd21);
    repeat (3) @(negedge clk);
    chk("s3_nemit", 64'(emit_cnt - e0), 64'd2);

    // overflow of the 32-bit accumulator
    q_mem[0] = pk(32767, 32767, 32767, 32767);
    k_mem[0] = pk(32767, 32767, 32767, 32767);
    cfg(1, 4, 1);
`ifdef SPDOT_SATURATE_EN
    pulse_start();
    expect_emit("ovf", 16'd0, 16'd0, 32'h7FFF_FFFF);
    wait_done("ovf");
    chk("ovf_csum", checksum_out, 64'h7FFF_FFFF);
`else
    pulse_start();
    expect_emit("ovf", 16'd0, 16'd0, 32'hFFFC_0004);
    wait_done("ovf");
    chk("ovf_csum", checksum_out, 64'hFFFF_FFFF_FFFC_0004);
`endif
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
